// File: rtl/fp_add_pipe.sv
// fp_add_pipe: three-stage pipelined floating-point adder/subtractor with
// valid/ready flow control and round-to-nearest-even.
//   Stage 1 unpacks the operands, orders them by magnitude, aligns the smaller
//   significand and classifies NaN/infinity.
//   Stage 2 adds or subtracts, then normalises.
//   Stage 3 rounds and packs. Its register drives y.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   operand handshake for a, b and op_sub (1: a-b, 0: a+b)
//   out_valid/out_ready result handshake for y
//   y                   rounded result {sign, exp, frac}
//   flags               {invalid, overflow, underflow, inexact}
// Optional feature: define FP_ADD_FLAGS_EN to add the flags port and its logic.
// y is identical with or without the macro.
module fp_add_pipe #(
  parameter int E_BITS = 5,
  parameter int M_BITS = 11,
  localparam int BITS = 1 + E_BITS + M_BITS - 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            op_sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] y
`ifdef FP_ADD_FLAGS_EN
  ,
  output logic [3:0]      flags
`endif
);

  localparam int F_BITS = M_BITS - 1;
  localparam int W      = M_BITS + 3;          // significand plus guard, round, sticky
  localparam int EXW    = E_BITS + 1;          // extra bit catches exponent overflow
  localparam int LZW    = $clog2(W + 1);
  localparam int SW     = (LZW > EXW) ? LZW : EXW;
  localparam int SIGW   = M_BITS + 1;
  localparam logic [E_BITS-1:0] EXP_ONES = '1;

  logic advance;

  // Stage 1: unpack, order by magnitude, align, classify specials
  logic              signA, signB, signBEff, swap;
  logic [E_BITS-1:0] expA, expB, bigExp, smallExp, bigExpEff, smallExpEff, expDiff;
  logic [F_BITS-1:0] fracA, fracB;
  logic [M_BITS-1:0] bigMan, smallMan;
  logic [2*W-1:0]    alignWide;
  logic              aIsNan, bIsNan, aIsInf, bIsInf, infInf;

  logic              s1Valid_d, s1Sign_d, s1Sub_d, s1Nan_d, s1Inf_d, s1InfSign_d;
  logic [E_BITS-1:0] s1Exp_d;
  logic [M_BITS-1:0] s1BigMan_d;
  logic [W-1:0]      s1Small_d;
  logic              s1Valid_q, s1Sign_q, s1Sub_q, s1Nan_q, s1Inf_q, s1InfSign_q;
  logic [E_BITS-1:0] s1Exp_q;
  logic [M_BITS-1:0] s1BigMan_q;
  logic [W-1:0]      s1Small_q;
`ifdef FP_ADD_FLAGS_EN
  logic              s1Invalid_d, s1Invalid_q, s2Invalid_q;
`endif

  assign {signA, expA, fracA} = a;
  assign {signB, expB, fracB} = b;
  assign signBEff = signB ^ op_sub;

  always_comb begin
    aIsNan = (expA == EXP_ONES) && (fracA != '0);
    bIsNan = (expB == EXP_ONES) && (fracB != '0);
    aIsInf = (expA == EXP_ONES) && (fracA == '0);
    bIsInf = (expB == EXP_ONES) && (fracB == '0);
    infInf = aIsInf && bIsInf && (signA ^ signBEff);

    // Raw {exp, frac} orders magnitudes correctly, including subnormals.
    swap        = {expB, fracB} > {expA, fracA};
    bigExp      = swap ? expB : expA;
    smallExp    = swap ? expA : expB;
    bigMan      = swap ? {|expB, fracB} : {|expA, fracA};
    smallMan    = swap ? {|expA, fracA} : {|expB, fracB};
    bigExpEff   = (bigExp == '0) ? E_BITS'(1) : bigExp;
    smallExpEff = (smallExp == '0) ? E_BITS'(1) : smallExp;
    expDiff     = bigExpEff - smallExpEff;

    // Low half of alignWide collects shifted-out bits and folds them into sticky.
    alignWide = '0;
    if (32'(expDiff) >= 32'(M_BITS + 2)) begin
      s1Small_d = {{(W-1){1'b0}}, |smallMan};
    end else begin
      alignWide = {smallMan, 3'b000, {W{1'b0}}} >> expDiff;
      s1Small_d = {alignWide[2*W-1:W+1], alignWide[W] | (|alignWide[W-1:0])};
    end

    s1Valid_d   = in_valid;
    s1Sign_d    = swap ? signBEff : signA;
    s1Sub_d     = signA ^ signBEff;
    s1Exp_d     = bigExpEff;
    s1BigMan_d  = bigMan;
    s1Nan_d     = aIsNan || bIsNan || infInf;
    s1Inf_d     = aIsInf || bIsInf;
    s1InfSign_d = aIsInf ? signA : signBEff;
`ifdef FP_ADD_FLAGS_EN
    // A NaN with a clear quiet bit is signalling.
    s1Invalid_d = infInf || (aIsNan && !fracA[F_BITS-1]) || (bIsNan && !fracB[F_BITS-1]);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
    end else if (advance) begin
      s1Valid_q   <= s1Valid_d;
      s1Sign_q    <= s1Sign_d;
      s1Sub_q     <= s1Sub_d;
      s1Exp_q     <= s1Exp_d;
      s1BigMan_q  <= s1BigMan_d;
      s1Small_q   <= s1Small_d;
      s1Nan_q     <= s1Nan_d;
      s1Inf_q     <= s1Inf_d;
      s1InfSign_q <= s1InfSign_d;
`ifdef FP_ADD_FLAGS_EN
      s1Invalid_q <= s1Invalid_d;
`endif
    end
  end

  // Stage 2: add/subtract and normalise
  logic [W:0]     sum;
  logic [EXW-1:0] expWide;
  logic [LZW-1:0] lzc;
  logic [SW-1:0]  lzcWide, shiftLimit, shamt;

  logic           s2Sign_d;
  logic [EXW-1:0] s2Exp_d;
  logic [W-1:0]   s2Mant_d;
  logic           s2Valid_q, s2Sign_q, s2Nan_q, s2Inf_q, s2InfSign_q;
  logic [EXW-1:0] s2Exp_q;
  logic [W-1:0]   s2Mant_q;

  always_comb begin
    sum     = s1Sub_q ? ({1'b0, s1BigMan_q, 3'b000} - {1'b0, s1Small_q})
                      : ({1'b0, s1BigMan_q, 3'b000} + {1'b0, s1Small_q});
    expWide = {1'b0, s1Exp_q};

    lzc = LZW'(W);
    for (int i = 0; i < W; i++) begin
      if (sum[i]) lzc = LZW'(W - 1 - i);
    end
    lzcWide    = SW'(lzc);
    shiftLimit = SW'(expWide - EXW'(1));
    shamt      = '0;

    if (sum[W]) begin
      s2Mant_d = {sum[W:2], sum[1] | sum[0]};
      s2Exp_d  = expWide + EXW'(1);
    end else begin
      // The left shift stops at the minimum exponent, so tiny results stay subnormal.
      shamt    = (lzcWide > shiftLimit) ? shiftLimit : lzcWide;
      s2Mant_d = sum[W-1:0] << shamt;
      s2Exp_d  = expWide - EXW'(shamt);
      if (!s2Mant_d[W-1]) s2Exp_d = '0;
    end

    // A zero from an effective subtraction (x-x) is +0 under round-to-nearest.
    s2Sign_d = (s1Sub_q && (sum == '0)) ? 1'b0 : s1Sign_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2Valid_q <= 1'b0;
    end else if (advance) begin
      s2Valid_q   <= s1Valid_q;
      s2Sign_q    <= s2Sign_d;
      s2Exp_q     <= s2Exp_d;
      s2Mant_q    <= s2Mant_d;
      s2Nan_q     <= s1Nan_q;
      s2Inf_q     <= s1Inf_q;
      s2InfSign_q <= s1InfSign_q;
`ifdef FP_ADD_FLAGS_EN
      s2Invalid_q <= s1Invalid_q;
`endif
    end
  end

  // Stage 3: round to nearest even, pack, force specials
  logic              guardBit, roundBit, stickyBit, roundUp, overflow;
  logic [SIGW-1:0]   sig;
  logic [EXW-1:0]    expR;
  logic [F_BITS-1:0] fracR;
  logic [BITS-1:0]   y_d, y_q;
  logic              outValid_q;

  always_comb begin
    guardBit  = s2Mant_q[2];
    roundBit  = s2Mant_q[1];
    stickyBit = s2Mant_q[0];
    roundUp   = guardBit && (roundBit || stickyBit || s2Mant_q[3]);
    sig       = {1'b0, s2Mant_q[W-1:3]} + SIGW'(roundUp);

    // A subnormal that rounds up into the hidden bit becomes the smallest normal.
    if (s2Exp_q == '0) expR = {{E_BITS{1'b0}}, sig[M_BITS-1]};
    else               expR = s2Exp_q + EXW'(sig[M_BITS]);

    fracR    = sig[M_BITS] ? {F_BITS{1'b0}} : sig[F_BITS-1:0];
    overflow = expR >= {1'b0, EXP_ONES};

    if (s2Nan_q)       y_d = {1'b0, EXP_ONES, 1'b1, {(F_BITS-1){1'b0}}};
    else if (s2Inf_q)  y_d = {s2InfSign_q, EXP_ONES, {F_BITS{1'b0}}};
    else if (overflow) y_d = {s2Sign_q, EXP_ONES, {F_BITS{1'b0}}};
    else               y_d = {s2Sign_q, expR[E_BITS-1:0], fracR};
  end

`ifdef FP_ADD_FLAGS_EN
  logic       finite, inexact;
  logic [3:0] flags_d, flags_q;

  always_comb begin
    finite  = !s2Nan_q && !s2Inf_q;
    inexact = finite && (guardBit || roundBit || stickyBit || overflow);
    flags_d = {s2Invalid_q,
               finite && overflow,
               finite && !overflow && (expR == '0) && inexact,
               inexact};
  end
`endif

  // The whole pipeline freezes while a result waits for the consumer.
  assign advance   = !outValid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = outValid_q;
  assign y         = y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      y_q        <= '0;
`ifdef FP_ADD_FLAGS_EN
      flags_q    <= '0;
`endif
    end else if (advance) begin
      outValid_q <= s2Valid_q;
      if (s2Valid_q) begin
        y_q     <= y_d;
`ifdef FP_ADD_FLAGS_EN
        flags_q <= flags_d;
`endif
      end
    end
  end

`ifdef FP_ADD_FLAGS_EN
  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: directed vectors for fp_add_pipe at half precision
// (E_BITS=5, M_BITS=11). Expected results are hand-computed IEEE binary16
// values. The bench also exercises stalls and a reset that arrives while
// operations are still in the pipeline.
module tb_fp_add_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y;
`ifdef FP_ADD_FLAGS_EN
  logic [3:0]  flags;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  // The four-operation stream: 1+1, 1-0.5, minSub+minSub, -1+0.5.
  logic [15:0] streamA [4] = '{16'h3C00, 16'h3C00, 16'h0001, 16'hBC00};
  logic [15:0] streamB [4] = '{16'h3C00, 16'h3800, 16'h0001, 16'h3800};
  logic        streamS [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [15:0] streamY [4] = '{16'h4000, 16'h3800, 16'h0002, 16'hB800};

  fp_add_pipe #(.E_BITS(5), .M_BITS(11)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
`ifdef FP_ADD_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Sends one operation, then checks the latency, y and (if enabled) the flags.
  task automatic applyStimulus(input string tag, input logic [15:0] av,
                               input logic [15:0] bv, input logic sub,
                               input logic [15:0] expY, input logic [3:0] expF);
    int lat;
    @(negedge clk);
    a        = av;
    b        = bv;
    op_sub   = sub;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_lat"}, 32'(lat), 32'd3);
    checkOutput({tag, "_y"}, 32'(y), 32'(expY));
`ifdef FP_ADD_FLAGS_EN
    checkOutput({tag, "_flags"}, 32'(flags), 32'(expF));
`else
    if (expF != 4'b0000) $display("[TB] %s: flags port disabled, expected flags %b", tag, expF);
`endif
    @(negedge clk);
  endtask

  // Sends four back-to-back operations and holds out_ready low for five
  // cycles once the first result appears.
  task automatic streamTest();
    int sent      = 0;
    int got       = 0;
    int stallLeft = 5;
    int stallSeen = 0;
    bit firstSeen = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      in_valid = (sent < 4);
      if (sent < 4) begin
        a      = streamA[sent];
        b      = streamB[sent];
        op_sub = streamS[sent];
      end
      #1;
      if (out_valid) firstSeen = 1'b1;
      if (firstSeen && stallLeft > 0) begin
        out_ready = 1'b0;
        stallLeft--;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (out_valid) begin
        checkOutput("stream_y", 32'(y), 32'(streamY[got]));
        if (!out_ready) stallSeen++;
        else got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("stream_count", 32'(got), 32'd4);
    checkOutput("stream_stall", 32'(stallSeen), 32'd5);
  endtask

  // Resets while two operations are in flight; neither may emerge.
  task automatic resetTest();
    int leaks = 0;
    @(negedge clk);
    a = 16'h3C00; b = 16'h3C00; op_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h3C01; b = 16'h1000;
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_y", 32'(y), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) leaks++;
    end
    checkOutput("rst_mid_leak", 32'(leaks), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op_sub    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_y", 32'(y), 32'd0);
`ifdef FP_ADD_FLAGS_EN
    checkOutput("reset_flags", 32'(flags), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

    applyStimulus("one_plus_one",   16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000);
    applyStimulus("one_minus_one",  16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0000);
    applyStimulus("negzero_sum",    16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0000);
    applyStimulus("tie_even_down",  16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'b0001);
    applyStimulus("tie_even_up",    16'h3C01, 16'h1000, 1'b0, 16'h3C02, 4'b0001);
    applyStimulus("round_carry",    16'h3FFF, 16'h1000, 1'b0, 16'h4000, 4'b0001);
    applyStimulus("overflow",       16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101);
    applyStimulus("inf_minus_inf",  16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'b1000);
    applyStimulus("inf_plus_one",   16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 4'b0000);
    applyStimulus("neginf_plus",    16'hFC00, 16'h3C00, 1'b0, 16'hFC00, 4'b0000);
    applyStimulus("qnan_in",        16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 4'b0000);
    applyStimulus("snan_in",        16'h7C01, 16'h3C00, 1'b0, 16'h7E00, 4'b1000);
    applyStimulus("norm_shift",     16'h3C00, 16'h3800, 1'b1, 16'h3800, 4'b0000);
    applyStimulus("neg_result",     16'h3800, 16'h3C00, 1'b1, 16'hB800, 4'b0000);
    applyStimulus("neg_big",        16'hBC00, 16'h3800, 1'b0, 16'hB800, 4'b0000);
    applyStimulus("subnormal_sum",  16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000);
    applyStimulus("to_subnormal",   16'h0400, 16'h0001, 1'b1, 16'h03FF, 4'b0000);
    applyStimulus("far_sticky",     16'h3C00, 16'h0001, 1'b0, 16'h3C00, 4'b0001);

    streamTest();
    resetTest();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
